// File: rtl/proc_trace_monitor_if.sv
// proc_trace_monitor_if: retirement, halt and trace-readout signals between the core side and the monitor
interface proc_trace_monitor_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32,
  parameter int DEPTH = 16
);
  localparam int FW = $clog2(DEPTH) + 1;
  logic              retire_valid;
  logic [XLEN-1:0]   retire_pc;
  logic [31:0]       retire_instr;
  logic              retire_we;
  logic [4:0]        retire_rd;
  logic [XLEN-1:0]   retire_wdata;
  logic              halt_in;
  logic              rd_ready;
  logic              rd_valid;
  logic [CNT_W-1:0]  rd_cycle;
  logic [XLEN-1:0]   rd_pc;
  logic [31:0]       rd_instr;
  logic              rd_we;
  logic [4:0]        rd_rd;
  logic [XLEN-1:0]   rd_wdata;
  logic [FW-1:0]     fill;
  logic [CNT_W-1:0]  cycle_count;
  logic              halted;
  logic              timed_out;
  logic              overflow;
  modport master (
    output retire_valid, retire_pc, retire_instr, retire_we, retire_rd, retire_wdata, halt_in, rd_ready,
    input  rd_valid, rd_cycle, rd_pc, rd_instr, rd_we, rd_rd, rd_wdata, fill, cycle_count, halted, timed_out, overflow
  );
  modport slave (
    input  retire_valid, retire_pc, retire_instr, retire_we, retire_rd, retire_wdata, halt_in, rd_ready,
    output rd_valid, rd_cycle, rd_pc, rd_instr, rd_we, rd_rd, rd_wdata, fill, cycle_count, halted, timed_out, overflow
  );
endinterface

// File: rtl/proc_trace_monitor.sv
// proc_trace_monitor: run-control FSM (halt/watchdog) with a show-ahead retirement trace buffer
module proc_trace_monitor #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 5000,
  parameter int CNT_W   = 32,
  parameter int RING    = 1
) (
  input logic                clock_proc,
  input logic                rst,
  proc_trace_monitor_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {RUN, HALTED, TIMED_OUT} state_t;
  typedef struct packed {
    logic [CNT_W-1:0] cyc;
    logic [XLEN-1:0]  pc;
    logic [31:0]      instr;
    logic             we;
    logic [4:0]       rd;
    logic [XLEN-1:0]  wdata;
  } rec_t;
  rec_t             mem_q [DEPTH];
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [AW:0]      fill_q, fill_d;
  logic             halted_q, timed_out_q, overflow_q;
  logic             push, pop, full, drop, wr, adv;
  always_comb begin
    push   = state_q == RUN && bus.retire_valid;
    pop    = fill_q != '0 && bus.rd_ready;
    full   = fill_q == (AW+1)'(DEPTH);
    drop   = push && full && !pop;
    // in ring mode a drop becomes an overwrite of the oldest entry
    wr     = !rst && push && (!full || pop || RING != 0);
    adv    = pop || (drop && RING != 0);
    head_d = head_q + AW'(adv);
    tail_d = tail_q + AW'(wr);
    fill_d = fill_q + (AW+1)'(push && !pop && !full) - (AW+1)'(pop && !push);
  end
  always_ff @(posedge clock_proc)
    if (wr) mem_q[tail_q] <= '{cnt_q, bus.retire_pc, bus.retire_instr, bus.retire_we, bus.retire_rd, bus.retire_wdata};
  always_ff @(posedge clock_proc) begin
    if (rst) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      fill_q      <= '0;
      halted_q    <= 1'b0;
      timed_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      fill_q     <= fill_d;
      overflow_q <= overflow_q | drop;
      if (state_q == RUN) begin
        if (bus.halt_in) begin
          state_q  <= HALTED;
          halted_q <= 1'b1;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          state_q     <= TIMED_OUT;
          timed_out_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end
  assign bus.rd_valid    = fill_q != '0;
  assign bus.rd_cycle    = mem_q[head_q].cyc;
  assign bus.rd_pc       = mem_q[head_q].pc;
  assign bus.rd_instr    = mem_q[head_q].instr;
  assign bus.rd_we       = mem_q[head_q].we;
  assign bus.rd_rd       = mem_q[head_q].rd;
  assign bus.rd_wdata    = mem_q[head_q].wdata;
  assign bus.fill        = fill_q;
  assign bus.cycle_count = cnt_q;
  assign bus.halted      = halted_q;
  assign bus.timed_out   = timed_out_q;
  assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_proc_trace_monitor.sv
// tb_proc_trace_monitor: three monitor variants (16 ring, 4 ring, 4 stop-on-full) against a queue-based reference
module tb_proc_trace_monitor;
  localparam int W  = 175;
  localparam int TO = 20;
  typedef struct packed {
    logic [31:0] cyc;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wdata;
  } rec_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst, rv, we, halt;
  logic [31:0] pc, instr, wdata;
  logic [4:0]  rd;
  logic        rdy [3];
  int          total = 0, bad = 0;
  rec_t        mq [3][$];
  int          mst [3];
  logic [31:0] mcnt [3];
  bit          movf [3];
  int          mdep [3] = '{16, 4, 4};
  bit          mring [3] = '{1'b1, 1'b1, 1'b0};
  logic [W-1:0] obs [3];
  proc_trace_monitor_if #(.XLEN(32), .CNT_W(32), .DEPTH(16)) if0 ();
  proc_trace_monitor_if #(.XLEN(32), .CNT_W(32), .DEPTH(4))  if1 ();
  proc_trace_monitor_if #(.XLEN(32), .CNT_W(32), .DEPTH(4))  if2 ();
  assign if0.retire_valid = rv;   assign if1.retire_valid = rv;   assign if2.retire_valid = rv;
  assign if0.retire_pc    = pc;   assign if1.retire_pc    = pc;   assign if2.retire_pc    = pc;
  assign if0.retire_instr = instr; assign if1.retire_instr = instr; assign if2.retire_instr = instr;
  assign if0.retire_we    = we;   assign if1.retire_we    = we;   assign if2.retire_we    = we;
  assign if0.retire_rd    = rd;   assign if1.retire_rd    = rd;   assign if2.retire_rd    = rd;
  assign if0.retire_wdata = wdata; assign if1.retire_wdata = wdata; assign if2.retire_wdata = wdata;
  assign if0.halt_in      = halt; assign if1.halt_in      = halt; assign if2.halt_in      = halt;
  assign if0.rd_ready = rdy[0];   assign if1.rd_ready = rdy[1];   assign if2.rd_ready = rdy[2];
  proc_trace_monitor #(.XLEN(32), .DEPTH(16), .TIMEOUT(TO), .CNT_W(32), .RING(1)) u0 (.clock_proc(clk), .rst(rst), .bus(if0));
  proc_trace_monitor #(.XLEN(32), .DEPTH(4),  .TIMEOUT(TO), .CNT_W(32), .RING(1)) u1 (.clock_proc(clk), .rst(rst), .bus(if1));
  proc_trace_monitor #(.XLEN(32), .DEPTH(4),  .TIMEOUT(TO), .CNT_W(32), .RING(0)) u2 (.clock_proc(clk), .rst(rst), .bus(if2));
  // head fields are don't-care while the buffer is empty
  assign obs[0] = {if0.rd_valid, if0.rd_valid ? {if0.rd_cycle, if0.rd_pc, if0.rd_instr, if0.rd_we, if0.rd_rd, if0.rd_wdata} : 134'(0),
                   5'(if0.fill), if0.cycle_count, if0.halted, if0.timed_out, if0.overflow};
  assign obs[1] = {if1.rd_valid, if1.rd_valid ? {if1.rd_cycle, if1.rd_pc, if1.rd_instr, if1.rd_we, if1.rd_rd, if1.rd_wdata} : 134'(0),
                   5'(if1.fill), if1.cycle_count, if1.halted, if1.timed_out, if1.overflow};
  assign obs[2] = {if2.rd_valid, if2.rd_valid ? {if2.rd_cycle, if2.rd_pc, if2.rd_instr, if2.rd_we, if2.rd_rd, if2.rd_wdata} : 134'(0),
                   5'(if2.fill), if2.cycle_count, if2.halted, if2.timed_out, if2.overflow};

  function automatic logic [W-1:0] exp_obs(int k);
    rec_t h = mq[k].size() != 0 ? mq[k][0] : '0;
    return {mq[k].size() != 0, h, 5'(mq[k].size()), mcnt[k], mst[k] == 1, mst[k] == 2, movf[k]};
  endfunction

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        mq[k].delete();
        mst[k] = 0;
        mcnt[k] = 0;
        movf[k] = 0;
      end else begin
        if (mq[k].size() != 0 && rdy[k]) void'(mq[k].pop_front());
        if (mst[k] == 0 && rv) begin
          if (mq[k].size() < mdep[k]) mq[k].push_back('{mcnt[k], pc, instr, we, rd, wdata});
          else begin
            movf[k] = 1;
            if (mring[k]) begin
              void'(mq[k].pop_front());
              mq[k].push_back('{mcnt[k], pc, instr, we, rd, wdata});
            end
          end
        end
        if (mst[k] == 0) begin
          if (halt) mst[k] = 1;
          else if (mcnt[k] == TO) mst[k] = 2;
          else mcnt[k] = mcnt[k] + 1;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic retire(input logic [31:0] p);
    rv = 1'b1;
    pc = p;
    instr = $urandom;
    we = 1'($urandom);
    rd = 5'($urandom);
    wdata = $urandom;
  endtask

  task automatic test_reset();
    rst = 1'b1; rv = 1'b0; halt = 1'b0; rdy = '{1'b0, 1'b0, 1'b0};
    pc = '0; instr = '0; we = 1'b0; rd = '0; wdata = '0;
    repeat (5) tick();
    for (int k = 0; k < 3; k++) begin
      total++;
      if (obs[k] !== exp_obs(k)) begin bad++; $display("FAIL reset k=%0d got=%h exp=%h", k, obs[k], exp_obs(k)); end
    end
    total++;
    if ({if0.rd_valid, if0.fill, if0.cycle_count, if0.halted, if0.timed_out, if0.overflow} !== 41'd0) begin
      bad++; $display("FAIL reset_const got fill=%0d cc=%0d valid=%b", if0.fill, if0.cycle_count, if0.rd_valid);
    end
    rst = 1'b0;
  endtask

  task automatic test_halt();
    for (int i = 0; i < 4; i++) begin
      retire(32'(4 * i));
      halt = i == 3;
      tick();
      for (int k = 0; k < 3; k++) begin
        total++;
        if (obs[k] !== exp_obs(k)) begin bad++; $display("FAIL halt_run k=%0d got=%h exp=%h", k, obs[k], exp_obs(k)); end
      end
    end
    rv = 1'b0; halt = 1'b0;
    tick();
    total++;
    if (if0.halted !== 1'b1 || if0.timed_out !== 1'b0 || if0.cycle_count !== 32'd3 || if0.fill !== 5'd4) begin
      bad++; $display("FAIL halt_state got halted=%b cc=%0d fill=%0d exp 1/3/4", if0.halted, if0.cycle_count, if0.fill);
    end
    rdy = '{1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      total++;
      if (if0.rd_valid !== 1'b1 || if0.rd_pc !== 32'(4 * i) || if0.rd_cycle !== 32'(i)) begin
        bad++; $display("FAIL halt_read%0d got v=%b pc=%h cyc=%0d exp pc=%h cyc=%0d", i, if0.rd_valid, if0.rd_pc, if0.rd_cycle, 4 * i, i);
      end
      tick();
    end
    rdy = '{1'b0, 1'b0, 1'b0};
    total++;
    if (if0.rd_valid !== 1'b0 || if1.rd_valid !== 1'b0) begin bad++; $display("FAIL halt_empty got v0=%b v1=%b exp 0", if0.rd_valid, if1.rd_valid); end
  endtask

  task automatic test_timeout();
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 25; i++) begin
      retire($urandom);
      tick();
      for (int k = 0; k < 3; k++) begin
        total++;
        if (obs[k] !== exp_obs(k)) begin bad++; $display("FAIL timeout_run k=%0d got=%h exp=%h", k, obs[k], exp_obs(k)); end
      end
    end
    rv = 1'b0;
    total++;
    if (if0.timed_out !== 1'b1 || if0.halted !== 1'b0 || if0.cycle_count !== 32'd20 || if0.fill !== 5'd16 || if0.overflow !== 1'b1) begin
      bad++; $display("FAIL timeout_state got to=%b h=%b cc=%0d fill=%0d ovf=%b", if0.timed_out, if0.halted, if0.cycle_count, if0.fill, if0.overflow);
    end
    total++;
    if (if0.rd_cycle !== 32'd5 || if2.rd_cycle !== 32'd0 || if2.fill !== 3'd4) begin
      bad++; $display("FAIL timeout_heads got ring=%0d stop=%0d exp 5 0", if0.rd_cycle, if2.rd_cycle);
    end
  endtask

  task automatic test_ring_overflow();
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      retire(32'(4 * i));
      halt = i == 5;
      tick();
      for (int k = 0; k < 3; k++) begin
        total++;
        if (obs[k] !== exp_obs(k)) begin bad++; $display("FAIL ovf_run k=%0d got=%h exp=%h", k, obs[k], exp_obs(k)); end
      end
    end
    rv = 1'b0; halt = 1'b0;
    total++;
    if (if1.fill !== 3'd4 || if1.overflow !== 1'b1 || if2.fill !== 3'd4 || if2.overflow !== 1'b1) begin
      bad++; $display("FAIL ovf_flags got f1=%0d o1=%b f2=%0d o2=%b", if1.fill, if1.overflow, if2.fill, if2.overflow);
    end
    rdy = '{1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      total++;
      if (if1.rd_pc !== 32'(8 + 4 * i) || if2.rd_pc !== 32'(4 * i)) begin
        bad++; $display("FAIL ovf_read%0d got ring=%h stop=%h exp %h %h", i, if1.rd_pc, if2.rd_pc, 8 + 4 * i, 4 * i);
      end
      tick();
    end
    rdy = '{1'b0, 1'b0, 1'b0};
  endtask

  task automatic test_push_pop_full();
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin retire(32'(4 * i)); tick(); end
    for (int i = 4; i < 10; i++) begin
      retire(32'(4 * i));
      rdy[1] = 1'b1;
      total++;
      if (if1.rd_pc !== 32'(4 * (i - 4))) begin bad++; $display("FAIL pp_head got=%h exp=%h", if1.rd_pc, 4 * (i - 4)); end
      tick();
      total++;
      if (if1.fill !== 3'd4 || if1.overflow !== 1'b0) begin bad++; $display("FAIL pp_fill got fill=%0d ovf=%b exp 4 0", if1.fill, if1.overflow); end
      for (int k = 0; k < 3; k++) begin
        total++;
        if (obs[k] !== exp_obs(k)) begin bad++; $display("FAIL pp_run k=%0d got=%h exp=%h", k, obs[k], exp_obs(k)); end
      end
    end
    rv = 1'b0; rdy[1] = 1'b0; halt = 1'b1;
    tick();
    halt = 1'b0;
    rdy[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (if1.rd_valid !== 1'b1 || if1.rd_pc !== 32'(24 + 4 * i)) begin bad++; $display("FAIL pp_read%0d got=%h exp=%h", i, if1.rd_pc, 24 + 4 * i); end
      tick();
    end
    rdy[1] = 1'b0;
  endtask

  task automatic test_mid_reset();
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin retire(32'(16 * i)); tick(); end
    rst = 1'b1; retire(32'h44); tick(); rst = 1'b0; rv = 1'b0;
    total++;
    if (if0.fill !== 5'd0 || if0.overflow !== 1'b0 || if0.cycle_count !== 32'd0 || if2.fill !== 3'd0 || if2.overflow !== 1'b0) begin
      bad++; $display("FAIL midrst got fill=%0d ovf=%b cc=%0d exp 0", if0.fill, if0.overflow, if0.cycle_count);
    end
    retire(32'h100); tick(); rv = 1'b0;
    total++;
    if (if0.fill !== 5'd1 || if0.rd_cycle !== 32'd0 || if0.rd_pc !== 32'h100) begin
      bad++; $display("FAIL midrst_rec got fill=%0d cyc=%0d pc=%h exp 1 0 100", if0.fill, if0.rd_cycle, if0.rd_pc);
    end
  endtask

  task automatic test_random();
    for (int ep = 0; ep < 4; ep++) begin
      rst = 1'b1; rv = 1'b0; halt = 1'b0; tick(); rst = 1'b0;
      for (int c = 0; c < 60; c++) begin
        retire($urandom);
        rv = $urandom_range(0, 3) != 0;
        halt = $urandom_range(0, 49) == 0;
        for (int k = 0; k < 3; k++) rdy[k] = $urandom_range(0, 2) == 0;
        tick();
        for (int k = 0; k < 3; k++) begin
          total++;
          if (obs[k] !== exp_obs(k)) begin bad++; $display("FAIL random ep=%0d c=%0d k=%0d got=%h exp=%h", ep, c, k, obs[k], exp_obs(k)); end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; rv = 1'b0; halt = 1'b0; rdy = '{1'b0, 1'b0, 1'b0};
    @(negedge clk);
    test_reset();
    test_halt();
    test_timeout();
    test_ring_overflow();
    test_push_pop_full();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
